// File: rtl/stl_skid_buf.sv
// Two-entry valid/ready skid buffer with registered o_valid/o_ready.
// Optional stall counter (o_stall_cnt) when STL_SKID_PERF_EN is defined.
module stl_skid_buf #(
  parameter int              WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_dout
`ifdef STL_SKID_PERF_EN
  ,
  output logic [31:0]      o_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] main_r;
  logic [WIDTH-1:0] skid_r;
  logic             valid_r;
  logic             ready_r;
  logic             in_fire_s;
  logic             out_fire_s;
  logic             load_main_din_s;
  logic             load_main_skid_s;
  logic             load_skid_s;

  assign in_fire_s  = i_valid && ready_r;
  assign out_fire_s = valid_r && i_ready;

  // Next-state and data-load decode; flush overrides every transfer.
  always_comb begin
    state_next_s     = state_r;
    load_main_din_s  = 1'b0;
    load_main_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    if (i_flush) begin
      state_next_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_fire_s) begin
            state_next_s    = ST_ONE;
            load_main_din_s = 1'b1;
          end else begin
            state_next_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_fire_s && out_fire_s) begin
            state_next_s    = ST_ONE;
            load_main_din_s = 1'b1;
          end else if (in_fire_s) begin
            state_next_s = ST_FULL;
            load_skid_s  = 1'b1;
          end else if (out_fire_s) begin
            state_next_s = ST_EMPTY;
          end else begin
            state_next_s = ST_ONE;
          end
        end
        ST_FULL: begin
          if (out_fire_s) begin
            state_next_s     = ST_ONE;
            load_main_skid_s = 1'b1;
          end else begin
            state_next_s = ST_FULL;
          end
        end
        default: begin
          state_next_s = ST_EMPTY;
        end
      endcase
    end
  end

  // State register; handshake outputs are precomputed from the next state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_EMPTY;
      valid_r <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_next_s;
      valid_r <= (state_next_s != ST_EMPTY);
      ready_r <= (state_next_s != ST_FULL);
    end
  end

  // Payload registers; flush leaves them untouched.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      main_r <= RESET_VAL;
      skid_r <= RESET_VAL;
    end else begin
      if (load_main_din_s) begin
        main_r <= i_din;
      end else if (load_main_skid_s) begin
        main_r <= skid_r;
      end else begin
        main_r <= main_r;
      end
      if (load_skid_s) begin
        skid_r <= i_din;
      end else begin
        skid_r <= skid_r;
      end
    end
  end

  assign o_valid = valid_r;
  assign o_ready = ready_r;
  assign o_dout  = main_r;

`ifdef STL_SKID_PERF_EN
  logic [31:0] stall_cnt_r;

  // Cycles where data is offered but the consumer holds off; wraps naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_r <= 32'd0;
    end else if (i_flush) begin
      stall_cnt_r <= 32'd0;
    end else if (valid_r && !i_ready) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign o_stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_stl_skid_buf.sv
// Self-checking bench for stl_skid_buf: directed scenarios plus random traffic
// checked against a queue-based FIFO reference.
module tb_stl_skid_buf;

  localparam int         WIDTH = 8;
  localparam logic [7:0] RV    = 8'h5A;

  logic       i_clk   = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_flush = 1'b0;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic [7:0] i_din   = 8'h00;
  logic       o_valid;
  logic       i_ready = 1'b0;
  logic [7:0] o_dout;
`ifdef STL_SKID_PERF_EN
  logic [31:0] o_stall_cnt;
`endif

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]  q[$];
  logic [7:0]  last_dout;
  int unsigned exp_stall;

  stl_skid_buf #(.WIDTH(WIDTH), .RESET_VAL(RV)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_flush),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_din   (i_din),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_dout  (o_dout)
`ifdef STL_SKID_PERF_EN
    ,
    .o_stall_cnt (o_stall_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic model_reset();
    q.delete();
    last_dout = RV;
    exp_stall = 0;
  endtask

  // Advance one clock and apply the FIFO rules to the reference queue.
  task automatic tick();
    bit         fl;
    bit         in_f;
    bit         out_f;
    bit         st;
    logic [7:0] d;
    fl    = i_flush;
    in_f  = i_valid && (q.size() < 2);
    out_f = (q.size() > 0) && i_ready;
    st    = (q.size() > 0) && !i_ready;
    d     = i_din;
    @(posedge i_clk);
    #1;
    if (fl) begin
      q.delete();
      exp_stall = 0;
    end else begin
      if (out_f) void'(q.pop_front());
      if (in_f) q.push_back(d);
      if (st) exp_stall = exp_stall + 1;
    end
    if (q.size() > 0) last_dout = q[0];
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    #12;
    vectors++;
    if (o_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    vectors++;
    if (o_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", o_ready); end
    vectors++;
    if (o_dout !== RV) begin miscompares++; $display("FAIL reset_dout: got %h expected %h", o_dout, RV); end
`ifdef STL_SKID_PERF_EN
    vectors++;
    if (o_stall_cnt !== 32'd0) begin miscompares++; $display("FAIL reset_stall: got %0d expected 0", o_stall_cnt); end
`endif
    model_reset();
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_stream();
    i_ready = 1'b1;
    i_valid = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      i_din = k[7:0];
      tick();
      vectors++;
      if (o_dout !== k[7:0] || o_dout !== last_dout) begin
        miscompares++; $display("FAIL stream_dout[%0d]: got %h expected %h", k, o_dout, k[7:0]);
      end
      vectors++;
      if (o_valid !== 1'b1 || o_ready !== 1'b1) begin
        miscompares++; $display("FAIL stream_hs[%0d]: got v=%b r=%b expected v=1 r=1", k, o_valid, o_ready);
      end
    end
    i_valid = 1'b0;
    tick();
    vectors++;
    if (o_valid !== 1'b0 || o_dout !== 8'h10) begin
      miscompares++; $display("FAIL stream_drain: got v=%b d=%h expected v=0 d=10", o_valid, o_dout);
    end
  endtask

  task automatic test_backpressure();
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_din   = 8'hA1;
    tick();
    vectors++;
    if (o_ready !== 1'b1 || o_dout !== 8'hA1) begin
      miscompares++; $display("FAIL bp_first: got r=%b d=%h expected r=1 d=a1", o_ready, o_dout);
    end
    i_din = 8'hA2;
    tick();
    vectors++;
    if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_dout !== 8'hA1) begin
      miscompares++; $display("FAIL bp_full: got r=%b v=%b d=%h expected r=0 v=1 d=a1", o_ready, o_valid, o_dout);
    end
    i_valid = 1'b0;
    i_din   = 8'hEE;
    tick();
    vectors++;
    if (o_ready !== 1'b0 || o_dout !== 8'hA1) begin
      miscompares++; $display("FAIL bp_hold: got r=%b d=%h expected r=0 d=a1", o_ready, o_dout);
    end
    i_ready = 1'b1;
    tick();
    vectors++;
    if (o_valid !== 1'b1 || o_dout !== 8'hA2 || o_ready !== 1'b1) begin
      miscompares++; $display("FAIL bp_second: got v=%b r=%b d=%h expected v=1 r=1 d=a2", o_valid, o_ready, o_dout);
    end
    tick();
    vectors++;
    if (o_valid !== 1'b0 || o_dout !== 8'hA2) begin
      miscompares++; $display("FAIL bp_empty: got v=%b d=%h expected v=0 d=a2", o_valid, o_dout);
    end
  endtask

  task automatic test_flush();
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_din   = 8'hB1;
    tick();
    i_din = 8'hB2;
    tick();
    i_din   = 8'hB3;
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    i_valid = 1'b0;
    vectors++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_dout !== 8'hB1) begin
      miscompares++; $display("FAIL flush_full: got v=%b r=%b d=%h expected v=0 r=1 d=b1", o_valid, o_ready, o_dout);
    end
    i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (o_valid !== 1'b0) begin miscompares++; $display("FAIL flush_nodeliver[%0d]: got v=%b expected 0", k, o_valid); end
    end
    // one entry held, new payload offered in the flush cycle must be dropped
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_din   = 8'hC1;
    tick();
    i_din   = 8'hC2;
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    i_valid = 1'b0;
    vectors++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_dout !== 8'hC1) begin
      miscompares++; $display("FAIL flush_drop: got v=%b r=%b d=%h expected v=0 r=1 d=c1", o_valid, o_ready, o_dout);
    end
  endtask

  task automatic test_async_reset();
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_din   = 8'hD1;
    tick();
    i_din = 8'hD2;
    tick();
    i_valid = 1'b0;
    vectors++;
    if (o_ready !== 1'b0 || o_valid !== 1'b1) begin
      miscompares++; $display("FAIL arst_prefull: got v=%b r=%b expected v=1 r=0", o_valid, o_ready);
    end
    #2;
    i_rst_n = 1'b0;
    #1;
    vectors++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_dout !== RV) begin
      miscompares++; $display("FAIL arst_immediate: got v=%b r=%b d=%h expected v=0 r=1 d=%h", o_valid, o_ready, o_dout, RV);
    end
    model_reset();
    #2;
    i_rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      i_valid = ($urandom % 4) != 0;
      i_ready = ($urandom % 3) != 0;
      i_flush = ($urandom % 32) == 0;
      i_din   = 8'($urandom);
      tick();
      vectors++;
      if (o_valid !== (q.size() > 0)) begin
        miscompares++; $display("FAIL rand_valid[%0d]: got %b expected %b", n, o_valid, q.size() > 0);
      end
      vectors++;
      if (o_ready !== (q.size() < 2)) begin
        miscompares++; $display("FAIL rand_ready[%0d]: got %b expected %b", n, o_ready, q.size() < 2);
      end
      vectors++;
      if (o_dout !== last_dout) begin
        miscompares++; $display("FAIL rand_dout[%0d]: got %h expected %h", n, o_dout, last_dout);
      end
`ifdef STL_SKID_PERF_EN
      vectors++;
      if (o_stall_cnt !== exp_stall) begin
        miscompares++; $display("FAIL rand_stall[%0d]: got %0d expected %0d", n, o_stall_cnt, exp_stall);
      end
`endif
    end
    i_flush = 1'b0;
    i_valid = 1'b0;
  endtask

`ifdef STL_SKID_PERF_EN
  task automatic test_perf();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_din   = 8'hE1;
    tick();
    i_valid = 1'b0;
    vectors++;
    if (o_stall_cnt !== 32'd0) begin miscompares++; $display("FAIL perf_start: got %0d expected 0", o_stall_cnt); end
    for (int k = 0; k < 5; k++) tick();
    vectors++;
    if (o_stall_cnt !== 32'd5 || o_stall_cnt !== exp_stall) begin
      miscompares++; $display("FAIL perf_count: got %0d expected 5", o_stall_cnt);
    end
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    vectors++;
    if (o_stall_cnt !== 32'd0) begin miscompares++; $display("FAIL perf_flush: got %0d expected 0", o_stall_cnt); end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
`ifdef STL_SKID_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
